// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter and other users of the
// 16-bit dual-port memory: FSM state encoding, default widths and a small
// helper for index widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the requesters / RAM port and the arbiter.
//   req, req_we, req_addr, req_wdata : per-requester request, packed by index
//   ack, rdata                       : completion pulse and returned data
//   mem_address, mem_write_data,
//   mem_write_enable, mem_read_data  : RAM port B
//   busy                             : arbiter has an access in flight
// slave  : arbiter view.
// master : requester + RAM view (also drives mem_read_data back).
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [ADDR_WIDTH-1:0]         mem_address;
    logic [DATA_WIDTH-1:0]         mem_write_data;
    logic                          mem_write_enable;
    logic [DATA_WIDTH-1:0]         mem_read_data;
    logic                          busy;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_read_data,
        output ack, rdata, mem_address, mem_write_data, mem_write_enable, busy
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_read_data,
        input  ack, rdata, mem_address, mem_write_data, mem_write_enable, busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   mask       : requesters excluded from this pick
//   last_grant : index of the previous winner
//   found      : some unmasked request is pending
//   idx        : first unmasked requester strictly after last_grant, wrapping
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   cand;

    // Walk offsets 1..NUM_REQ from the pointer; last_grant itself is the
    // final candidate, so a lone requester can still win again.
    always_comb begin
        eligible = req & ~mask;
        found    = 1'b0;
        idx      = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NUM_REQ requesters.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : requester handshake and RAM port (see mem_port_arbiter_if)
//
// state | meaning
// IDLE  | no access in flight
// BUSY  | access presented to the RAM; it executes on the falling edge
// ACK   | completion cycle, ack/rdata valid; next winner may be loaded
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      last_grant_q;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]    pick_mask;
    logic                  pick_found;
    logic                  load;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic                  we_sel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (bus.req),
        .mask       (pick_mask),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = pick_found ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_d = ST_ACK;
            ST_ACK:  state_d = pick_found ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // In ACK the acknowledged requester still shows its old req, so it is
    // masked out to avoid serving the same transfer twice.
    always_comb begin
        bus.busy  = (state_q == ST_BUSY);
        pick_mask = '0;
        if (state_q == ST_ACK) pick_mask[grant_q] = 1'b1;
        load = pick_found && ((state_q == ST_IDLE) || (state_q == ST_ACK));
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                addr_sel  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_sel = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                we_sel    = bus.req_we[i];
            end
        end
    end

    // Write enable is only ever set on a load, so it is high for exactly the
    // BUSY cycle of a write and the RAM commits it once.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q              <= '0;
            last_grant_q         <= IDX_W'(NUM_REQ - 1);
            bus.ack              <= '0;
            bus.rdata            <= '0;
            bus.mem_address      <= '0;
            bus.mem_write_data   <= '0;
            bus.mem_write_enable <= 1'b0;
        end else begin
            bus.ack              <= '0;
            bus.mem_write_enable <= 1'b0;
            if (load) begin
                grant_q              <= pick_idx;
                bus.mem_address      <= addr_sel;
                bus.mem_write_data   <= wdata_sel;
                bus.mem_write_enable <= we_sel;
            end
            if (state_q == ST_BUSY) begin
                bus.rdata    <= bus.mem_read_data;
                bus.ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                last_grant_q <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] rdata;
        logic [31:0] cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   we_cnt = 0;

    logic [15:0] ram     [0:65535];
    logic [15:0] ref_mem [0:65535];

    txn_t rq [NR][$];
    exp_t exp_q [$];
    int   linger [NR];
    int   chg_at [NR];
    int   m_left [NR];
    int   model_ptr;
    exp_t mon_e;

    mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM port B: operation happens on the falling edge, writes pass through.
    always @(negedge clock) begin
        if (bus.mem_write_enable) begin
            ram[bus.mem_address] = bus.mem_write_data;
            bus.mem_read_data    = bus.mem_write_data;
            we_cnt++;
        end else begin
            bus.mem_read_data = ram[bus.mem_address];
        end
    end

    // Scoreboard monitor: every ack is matched against the next prediction.
    always @(negedge clock) begin
        if (bus.ack != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_grant", 32'(bus.ack), 32'd1 << mon_e.idx);
                check("ack_rdata", 32'(bus.rdata), 32'(mon_e.rdata));
                check("ack_cycle", 32'(cyc), mon_e.cyc);
                check("busy_in_ack", 32'(bus.busy), 32'd0);
            end
        end
        if (bus.mem_write_enable) check("we_only_busy", 32'(bus.busy), 32'd1);
    end

    function automatic txn_t mk_txn(input logic we, input logic [15:0] addr, input logic [15:0] data);
        txn_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        return t;
    endfunction

    task automatic drive(input int i, input logic on, input txn_t t);
        bus.req[i]                = on;
        bus.req_we[i]             = t.we;
        bus.req_addr[i*AW +: AW]  = t.addr;
        bus.req_wdata[i*DW +: DW] = t.data;
    endtask

    // Next requester strictly after the pointer with work left, skipping excl.
    function automatic int model_pick(input int excl);
        for (int d = 1; d <= NR; d++) begin
            int j;
            j = (model_ptr + d) % NR;
            if (j != excl && m_left[j] > 0) return j;
        end
        return -1;
    endfunction

    // Called just after a rising edge. Predicts service order, ack cycles and
    // data for everything queued in rq, then plays the requesters.
    task automatic run_batch(input string name);
        int   taken [NR];
        int   arb, w, nxt, writes, we0, budget;
        bit   done;
        txn_t t;
        exp_t e;
        logic [15:0] rd;
        writes = 0;
        we0    = we_cnt;
        for (int i = 0; i < NR; i++) begin
            m_left[i] = rq[i].size();
            taken[i]  = 0;
            chg_at[i] = -1;
        end
        arb = cyc + 1;
        w   = model_pick(-1);
        while (w >= 0) begin
            t = rq[w][taken[w]];
            taken[w]++;
            m_left[w]--;
            if (t.we) begin
                ref_mem[t.addr] = t.data;
                rd = t.data;
                writes++;
            end else begin
                rd = ref_mem[t.addr];
            end
            e.idx   = 8'(w);
            e.rdata = rd;
            e.cyc   = 32'(arb + 1);
            exp_q.push_back(e);
            model_ptr = w;
            nxt = model_pick(w);
            if (nxt >= 0) begin
                arb += 2;
                w = nxt;
            end else if (m_left[w] > 0) begin
                arb += 3;
            end else begin
                w = -1;
            end
        end

        for (int i = 0; i < NR; i++)
            if (rq[i].size() > 0) drive(i, 1'b1, rq[i][0]);
        budget = 0;
        done   = 1'b0;
        while (!done) begin
            @(posedge clock);
            #1;
            budget++;
            for (int i = 0; i < NR; i++) begin
                if (chg_at[i] == cyc) begin
                    chg_at[i] = -1;
                    if (rq[i].size() > 0) drive(i, 1'b1, rq[i][0]);
                    else bus.req[i] = 1'b0;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.ack[i]) begin
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                    chg_at[i] = cyc + 1 + linger[i];
                end
            end
            done = (exp_q.size() == 0);
            for (int i = 0; i < NR; i++)
                if (rq[i].size() > 0 || chg_at[i] >= 0) done = 1'b0;
            if (!done && budget > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_timeout: %0d acks still outstanding, required 0", name, exp_q.size());
                exp_q.delete();
                for (int i = 0; i < NR; i++) begin
                    rq[i].delete();
                    chg_at[i] = -1;
                end
                bus.req = '0;
                done = 1'b1;
            end
        end
        repeat (3) @(posedge clock);
        #1;
        check({name, "_we_cycles"}, 32'(we_cnt - we0), 32'(writes));
        for (int i = 0; i < NR; i++) linger[i] = 0;
    endtask

    initial begin
        bus.req           = '0;
        bus.req_we        = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.mem_read_data = '0;
        for (int a = 0; a < 65536; a++) begin
            ram[a]     = '0;
            ref_mem[a] = '0;
        end
        for (int i = 0; i < NR; i++) begin
            linger[i] = 0;
            chg_at[i] = -1;
        end
        ram[16'h0040]     = 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_we", 32'(bus.mem_write_enable), 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_wdata", 32'(bus.mem_write_data), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        reset     = 1'b0;
        model_ptr = NR - 1;
        @(posedge clock);
        #1;

        // Three-way contention: every requester writes then reads back.
        for (int i = 0; i < NR; i++) begin
            rq[i].push_back(mk_txn(1'b1, 16'h1000 + 16'(i), 16'hC0D0 + 16'(i)));
            rq[i].push_back(mk_txn(1'b0, 16'h1000 + 16'(i), 16'h0000));
        end
        run_batch("contention");

        // Requester 0 lingers past its ack while requester 1 is pending.
        rq[0].push_back(mk_txn(1'b1, 16'h0020, 16'h5555));
        rq[1].push_back(mk_txn(1'b0, 16'h0020, 16'h0000));
        linger[0] = 1;
        run_batch("b2b_mask");

        rq[1].push_back(mk_txn(1'b0, 16'h0040, 16'h0000));
        run_batch("single_read");

        rq[0].push_back(mk_txn(1'b1, 16'h0100, 16'h1234));
        run_batch("single_write");
        rq[0].push_back(mk_txn(1'b0, 16'h0100, 16'h0000));
        run_batch("read_back");

        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            check("idle_ack", 32'(bus.ack), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_we", 32'(bus.mem_write_enable), 32'd0);
        end

        for (int b = 0; b < 20; b++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 9) < 7 || (i == NR - 1 && !any)) begin
                    int n;
                    any = 1'b1;
                    n = $urandom_range(1, 3);
                    for (int k = 0; k < n; k++)
                        rq[i].push_back(mk_txn(1'($urandom_range(0, 1)),
                                               16'h0300 + 16'($urandom_range(0, 3)),
                                               16'($urandom)));
                end
            end
            run_batch("random");
        end

        // Reset on the edge that would leave IDLE: no access starts.
        drive(0, 1'b1, mk_txn(1'b0, 16'h0040, 16'h0000));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_idle_busy", 32'(bus.busy), 32'd0);
        check("rst_idle_we", 32'(bus.mem_write_enable), 32'd0);
        bus.req   = '0;
        reset     = 1'b0;
        model_ptr = NR - 1;
        repeat (4) @(posedge clock);
        #1;
        check("rst_idle_after", 32'(bus.busy), 32'd0);

        // Reset during the BUSY cycle of a write.
        drive(2, 1'b1, mk_txn(1'b1, 16'h0200, 16'hAAAA));
        @(posedge clock);
        #1;
        check("rstw_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rstw_ack", 32'(bus.ack), 32'd0);
        check("rstw_busy_after", 32'(bus.busy), 32'd0);
        check("rstw_we", 32'(bus.mem_write_enable), 32'd0);
        check("rstw_addr", 32'(bus.mem_address), 32'd0);
        check("rstw_wdata", 32'(bus.mem_write_data), 32'd0);
        check("rstw_rdata", 32'(bus.rdata), 32'd0);
        check("rstw_mem", 32'(ram[16'h0200]), 32'h0000AAAA);
        bus.req   = '0;
        reset     = 1'b0;
        model_ptr = NR - 1;
        repeat (4) @(posedge clock);
        #1;
        check("rstw_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one port of the 16-bit dual-port `memory` block between `NUM_REQ` requesters, such as the display fetcher, the I/O/DMA engine and the debug loader. It uses round-robin arbitration with a req/ack handshake. The RAM performs its access on the falling clock edge, so the block issues one access per grant and returns read data with a fixed latency. Under contention it sustains one access every 2 cycles. It sits between the requesters and the `address_b` / `write_data_b` / `write_enable_b` / `read_data_b` port of the RAM.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_WIDTH`, 16: memory address width.
- `DATA_WIDTH`, 16: memory word width.

Ports, one per line: name, direction, width, meaning.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: request per requester; held high until the matching ack.
- `req_we` in NUM_REQ: 1 = write, 0 = read. Held with `req`.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data, sliced the same way.
- `ack` out NUM_REQ: one-cycle completion pulse, one-hot or zero.
- `rdata` out DATA_WIDTH: data for the acknowledged access; valid while `ack` is nonzero.
- `mem_address` out ADDR_WIDTH: to the RAM port address.
- `mem_write_data` out DATA_WIDTH: to the RAM port write data.
- `mem_write_enable` out 1: to the RAM port write enable.
- `mem_read_data` in DATA_WIDTH: from the RAM port read data.
- `busy` out 1: high in BUSY.

## Operation
- **States.**
  - IDLE: no access in flight.
  - BUSY: access presented to the RAM. The RAM executes it at the falling edge mid-cycle.
  - ACK: completion cycle.
- **IDLE.** If any `req` is high, pick a winner round-robin: the first requester strictly after `last_grant`, with wrap-around.
  - Register the winner's addr, wdata and we into the `mem_*` outputs and its index into `grant`.
  - Go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY.**
  - Capture `rdata <= mem_read_data`, pulse `ack[grant]` in the next cycle, and set `last_grant <= grant`.
  - Go to ACK.
  - For a write, `rdata` equals the written data because the RAM passes it through.
- **ACK.** Arbitrate again with `req[grant]` masked off.
  - If another requester is pending, load it and go to BUSY (back-to-back).
  - Otherwise go to IDLE.
  - The requester that is being acknowledged drops or changes `req` on the edge that ends ACK.
- `mem_write_enable` is high only in BUSY. It is forced low in IDLE and ACK so a write commits exactly once.
- `mem_address` and `mem_write_data` hold their last value outside BUSY.
- A requester that drops `req` during BUSY does not cancel the access; its ack still pulses.
- `req_*` changes from the winner during BUSY are ignored; the values were latched at the grant.

## Timing
- **Reset values.**
  - State IDLE.
  - `ack`=0, `busy`=0, `mem_write_enable`=0, `mem_address`=0, `mem_write_data`=0, `rdata`=0.
  - `last_grant`=NUM_REQ-1, so requester 0 wins first after reset.
- **Latency.** `req` sampled high at edge E puts the access in BUSY during the cycle after E. `ack` and `rdata` are valid in the cycle after that, i.e. the ack cycle is E+2.
- **Throughput.** 1 access per 2 cycles while any other requester is pending; 1 per 3 cycles for a single requester re-requesting.
- **Fairness.** No requester waits more than NUM_REQ-1 grants.
- **Reset during BUSY.** The falling-edge RAM operation has already happened, so the write commits. No ack is issued and the state goes to IDLE.
- **Reset on the edge ending IDLE.** No access is issued.
- **Simultaneous requests.** Resolved purely by the round-robin pointer; no fixed priority except immediately after reset.

## Structure
- Shared definitions file: state encodings (IDLE=2'd0, BUSY=2'd1, ACK=2'd2) and the default ADDR_WIDTH / DATA_WIDTH, reused by `memory` users.
- One sub-module: `rr_pick`. It is combinational and parameterized by NUM_REQ.
  - Inputs: request vector, mask, `last_grant`.
  - Outputs: `found` and a binary index.
- The FSM, output registers and handshake logic live in `mem_port_arbiter`.

## Test plan
- **Single read.** Memory preloaded so [0x0040]=0xBEEF; req[1] read 0x0040 at cycle 0. Required: ack[1] in cycle 2 with `rdata`=0xBEEF; no other ack.
- **Single write then read.** req[0] writes 0x1234 to 0x0100. Required: ack[0] with `rdata`=0x1234 and `mem_write_enable` high for exactly 1 cycle. A subsequent read of 0x0100 returns 0x1234.
- **Three-way contention.** req[2:0]=3'b111 held and each re-raised after its ack. Required: grant order 0,1,2,0,… and acks spaced 2 cycles apart.
- **Back-to-back masking.** req[0] and req[1] are both high and req[0] keeps `req` high one cycle past its ack. Required: no double grant to 0; requester 1 is served next.
- **Reset mid-write.** Reset is asserted during the BUSY cycle of a write of 0xAAAA to 0x0200. Required: no ack; all outputs at reset values next cycle; [0x0200]=0xAAAA.
- **Idle.** No requests for 10 cycles. Required: `mem_write_enable`=0, `ack`=0, `busy`=0 throughout.
